// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, default
// latencies, FSM state type and the busy-counter width helper.
package mdu_unit_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_MADD  = 3'd7;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Counter must hold the longer latency; never narrower than 4 bits.
  function automatic int mdu_cnt_width(input int mult_n, input int div_n);
    int mx;
    int w;
    mx = (mult_n > div_n) ? mult_n : div_n;
    w  = $clog2(mx + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the MDU.
interface mdu_unit_if;
  logic        start;
  logic        cancel;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, cancel, op, a, b, input busy, hi, lo);
  modport slave  (input start, cancel, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_compute.sv
// Combinational MDU datapath: produces the HI/LO values an op would leave
// behind, given the operands and the current HI/LO.
// Optional MADD accumulate is built only when MDU_MADD_EN is defined.
module mdu_compute
  import mdu_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        div_by_zero
);

  logic [63:0]        a_sx, b_sx, a_zx, b_zx;
  logic [63:0]        prod_s, prod_u;
  logic               b_zero, div_ovf;
  logic [31:0]        b_sdiv, b_udiv;
  logic signed [31:0] s_quo, s_rem;
  logic [31:0]        u_quo, u_rem;

  // Low 64 bits of the extended operands' product are the exact product.
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign a_zx   = {32'd0, a};
  assign b_zx   = {32'd0, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divide by 1 instead of 0 or of -1 on overflow: this keeps the
  // divider well defined and yields exactly lo = 0x80000000, hi = 0.
  assign b_zero  = (b == 32'd0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_sdiv  = (b_zero || div_ovf) ? 32'd1 : b;
  assign b_udiv  = b_zero ? 32'd1 : b;
  assign s_quo   = $signed(a) / $signed(b_sdiv);
  assign s_rem   = $signed(a) % $signed(b_sdiv);
  assign u_quo   = a / b_udiv;
  assign u_rem   = a % b_udiv;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo} + prod_s;
`endif

  // Select the result for the requested op; unchanged HI/LO by default.
  always_comb begin
    next_hi     = hi;
    next_lo     = lo;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT:  {next_hi, next_lo} = prod_s;
      MDU_MULTU: {next_hi, next_lo} = prod_u;
      MDU_DIV: begin
        div_by_zero = b_zero;
        if (!b_zero) begin
          next_lo = s_quo;
          next_hi = s_rem;
        end
      end
      MDU_DIVU: begin
        div_by_zero = b_zero;
        if (!b_zero) begin
          next_lo = u_quo;
          next_hi = u_rem;
        end
      end
      MDU_MTHI:  next_hi = a;
      MDU_MTLO:  next_lo = a;
`ifdef MDU_MADD_EN
      MDU_MADD:  {next_hi, next_lo} = acc;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: architectural HI/LO plus a busy down-counter that
// models fixed MULT/DIV latency. Results are computed at acceptance, parked
// in pending registers, and committed when the counter reaches terminal count.
// Optional feature macro: MDU_MADD_EN (op 7 = signed multiply-accumulate).
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   MDU_IDLE | busy = 0; accepts MTHI/MTLO (immediate) or long ops
//   MDU_RUN  | busy = 1; counter runs down, pending committed at 1->0
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  mdu_unit_if.slave bus
);

  localparam int              CNT_W  = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             dbz_q, dbz_d;

  logic             accept, is_move, is_mult, is_div;
  logic [31:0]      next_hi, next_lo;
  logic             div_by_zero;

  mdu_compute u_compute (
    .op          (bus.op),
    .a           (bus.a),
    .b           (bus.b),
    .hi          (hi_q),
    .lo          (lo_q),
    .next_hi     (next_hi),
    .next_lo     (next_lo),
    .div_by_zero (div_by_zero)
  );

  assign accept  = bus.start && !bus.cancel && (state_q == MDU_IDLE);
  assign is_move = (bus.op == MDU_MTHI) || (bus.op == MDU_MTLO);
  assign is_div  = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
`ifdef MDU_MADD_EN
  assign is_mult = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU) || (bus.op == MDU_MADD);
`else
  assign is_mult = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
`endif

  assign bus.busy = (state_q == MDU_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Next-state: accept in IDLE, count down in RUN, commit at terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          if (is_move) begin
            hi_d = next_hi;
            lo_d = next_lo;
          end else if (is_mult || is_div) begin
            pend_hi_d = next_hi;
            pend_lo_d = next_lo;
            dbz_d     = div_by_zero;
            cnt_d     = is_div ? DIV_N : MULT_N;
            state_d   = MDU_RUN;
          end
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          // Divide by zero runs the full latency but leaves HI/LO alone.
          if (!dbz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // State, counter, pending and HI/LO registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the execute stage, beside the ALU.
- Operand b comes from the same E-stage operand mux that selects between the register file value and the extender's 32-bit immediate output.
- Holds the architectural HI/LO registers and models fixed multi-cycle MULT/DIV latency with a busy counter.
- The hazard unit stalls HI/LO-dependent and MDU instructions in D while the unit is busy.

Parameters:
- MULT_CYCLES, 5, cycles busy is held high after a multiply start (must be ≥ 1).
- DIV_CYCLES, 10, cycles busy is held high after a divide start (must be ≥ 1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  E-stage instruction is an MDU op this cycle.
- cancel  input  1  exception/interrupt flush of the E-stage instruction; suppresses start this cycle.
- op  input  3  operation code (see Behaviour).
- a  input  32  operand rs.
- b  input  32  operand rt (from the E operand mux).
- busy  output  1  multi-cycle operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (only with the macro; otherwise treated as NONE).
- Reset, asynchronous, when reset_n = 0: hi = 0, lo = 0, busy = 0, counter = 0, pending registers = 0. Reset mid-operation discards the in-flight result.
- Accept condition: start & ~cancel & ~busy. When start = 1 while busy = 1, the request is ignored (the stall logic guarantees it never occurs); no state changes.
- MTHI/MTLO: hi <= a (or lo <= a) at the accepting edge; busy stays 0; zero latency.
- MULT/MULTU/DIV/DIVU, at the accepting edge t:
  - The result is computed combinationally and captured in pending_hi/pending_lo.
  - counter <= N, where N is MULT_CYCLES or DIV_CYCLES; busy <= 1.
  - Each subsequent edge decrements counter.
  - At edge t+N: hi/lo <= pending, busy <= 0.
  - busy is therefore high for exactly N cycles. hi/lo keep their old values until edge t+N.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b = 0, DIV or DIVU): busy still runs for DIV_CYCLES; hi/lo are left unchanged at completion.
- The busy counter is 4-bit minimum, sized as $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Hazard unit stalls on (busy | start) for any MDU or MFHI/MFLO instruction in D. That logic lives outside this block.
- cancel = 1 with start = 1: no state change. cancel has no effect on an already-running operation, which completes normally.
- op = NONE with start = 1: no state change.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 7 MADD is accepted. {hi,lo} <= {hi,lo} + signed(a)*signed(b), mod 2^64.
  - The accumulate base is the hi/lo value at the accepting edge.
  - Latency is MULT_CYCLES.
- Undefined: op 7 is treated as NONE (no state change, busy stays 0).

Decomposition:
- Op-code constants MDU_NONE..MDU_MADD belong in the shared settings header with the other control encodings. So do the default cycle counts.
- One natural sub-module: mdu_compute.
  - Purely combinational.
  - Inputs: op, a, b, hi, lo. Outputs: next_hi, next_lo, div_by_zero.
  - mdu_unit keeps the counter, busy, pending and HI/LO registers.

Test Plan:
- MULT: a = 0xFFFFFFFE, b = 3, start one cycle → busy high 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; hi/lo unchanged during busy.
- MULTU: same operands → hi = 0x00000002, lo = 0xFFFFFFFA after 5 cycles.
- DIV: a = -7, b = 2 → busy 10 cycles; then lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- DIV overflow 0x80000000/0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU by zero with hi = 0x11, lo = 0x22 → busy 10 cycles, hi/lo stay 0x11/0x22.
- MTHI a = 0xDEADBEEF → hi updates next edge, busy 0.
- start + cancel MULT → no busy, hi/lo unchanged.
- reset_n pulsed low at cycle 3 of a DIV → busy, hi, lo = 0 immediately, asynchronously before the next clock edge. No late write after reset release.
- MDU_MADD_EN defined: hi = 0, lo = 0xFFFFFFFF, MADD 1×1 → hi = 1, lo = 0 after 5 cycles.
- MDU_MADD_EN undefined: op 7 → busy stays 0, no change.
